mem_stage: RTL
==============

Name: mem_stage

Overview:
Memory stage of the Y86-64 pipeline and the consumer of the execute stage's e_* outputs. It holds the E/M pipeline register and performs data-memory reads and writes over a req/ack handshake with a timeout. It produces m_valM and m_stat for writeback and forwarding. m_busy is raised while a memory access is outstanding so the hazard unit can stall.

Parameters:
MEM_BYTES, 8192, data memory size in bytes; valid 8-byte access requires addr <= MEM_BYTES-8
TIMEOUT, 16, max cycles in REQ before the access is aborted as ADR
STAT_AOK/HLT/ADR/INS, 4'b0001/0010/0100/1000, one-hot stat encoding (bit0 AOK, bit1 HLT, bit2 ADR, bit3 INS)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
e_stat  in  4  stat from execute
e_icode  in  4  icode from execute
e_cnd  in  1  condition flag from execute
e_valE  in  64  ALU result from execute
e_valA  in  64  valA from execute
e_dstE  in  4  dest E register (15 = none)
e_dstM  in  4  dest M register (15 = none)
M_stall  in  1  hold E/M register
M_bubble  in  1  load nop bubble into E/M register
M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM  out  4/4/1/64/64/4/4  registered E/M contents, used for forwarding
m_valM  out  64  read data (0 for non-read instructions)
m_stat  out  4  stat after memory stage
m_busy  out  1  access outstanding; stall request
dmem_req  out  1  memory request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  64  byte address
dmem_wdata  out  64  write data
dmem_rdata  in  64  read data, valid with ack
dmem_ack  in  1  access complete
dmem_err  in  1  access failed, valid with ack

Behaviour:
- Reset (async, rst_n=0): E/M register = bubble (stat AOK, icode 1, cnd 0, valE = valA = 0, dstE = dstM = 15). State IDLE, timeout counter 0. m_valM 0, m_busy 0, dmem_req/we 0, dmem_addr/wdata 0.
- E/M load, on a rising edge only when !M_stall && !m_busy:
  - M_bubble=1: load the bubble values.
  - Otherwise: load the e_* inputs.
  - When m_busy=1 the register holds regardless of M_stall/M_bubble.
- Access decode on the loaded values:
  - Write, addr = valE, data = valA: icode 4 (rmmovq), 8 (call), 10 (pushq).
  - Read, addr = valE: icode 5 (mrmovq).
  - Read, addr = valA: icode 9 (ret), 11 (popq).
- Issue rule: an access is issued only if loaded stat == AOK and addr <= MEM_BYTES-8.
- Invalid address: no request is issued; m_stat = ADR, state DONE.
- Non-AOK stat: no request; m_stat passes M_stat through.
- FSM, states IDLE / REQ / DONE; next state is computed on the same edge as the E/M load:
  - Load with an issuable access -> REQ.
  - Load with a non-memory instruction or an invalid/non-AOK access -> DONE.
  - Bubble -> IDLE.
  - REQ: dmem_req=1, m_busy=1; dmem_we, dmem_addr, dmem_wdata driven from the E/M register. The counter increments each cycle.
  - REQ with dmem_ack=1: capture dmem_rdata (reads) into m_valM, set err flag = dmem_err, -> DONE. An ack in the first REQ cycle is legal (1-cycle access).
  - REQ with counter reaching TIMEOUT-1 and no ack: set err flag, -> DONE. dmem_req drops next cycle.
  - DONE/IDLE: dmem_req=0, m_busy=0. State is held until the next load.
- m_stat:
  - ADR if err flag is set or the address is invalid.
  - Else M_stat.
  - Bubble/IDLE gives AOK.
- m_valM: captured read data in DONE for read icodes; 0 otherwise, including writes and errors.
- dmem_ack while not in REQ: ignored.
- Reset mid-REQ: dmem_req drops immediately; a late ack is ignored.
- M_bubble and M_stall both high: stall wins and the register holds.
- No combinational path from e_* to dmem_* or m_* outputs; all outputs derive from registered state.

Test Plan:
- Reset: rst_n=0 mid-REQ -> dmem_req=0 asynchronously; M_icode=1, M_dstE=15, m_stat=0001, m_busy=0.
- mrmovq: e_icode=5, e_valE=0x100, memory acks after 3 cycles with 0xDEADBEEF -> m_busy high for 3 cycles; dmem_we=0, dmem_addr=0x100; then m_valM=0xDEADBEEF, m_stat=0001.
- pushq: e_icode=10, e_valE=0x1FF8, e_valA=0x55, immediate ack -> dmem_we=1, addr=0x1FF8, wdata=0x55 for exactly 1 cycle; m_valM=0.
- Bad address: rmmovq with e_valE=0x1FF9 -> no dmem_req; m_stat=0100, m_busy=0.
- Timeout: popq with e_valA=0x40, no ack -> dmem_req high for 16 cycles, then m_stat=0100, m_valM=0. A later stray ack is ignored.
- Stall/bubble: M_stall=1 while e_* changes -> M_* unchanged. M_bubble=1, M_stall=0 -> M_icode=1, M_dstM=15. HLT stat (e_stat=0010) on mrmovq -> no request, m_stat=0010.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of the Y86-64 pipeline: holds the E/M pipeline register,
// runs data-memory reads and writes over a req/ack handshake with a timeout,
// and produces m_valM / m_stat for writeback and forwarding.
module mem_stage #(
    parameter int MEM_BYTES = 8192,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // execute stage outputs
    input  logic [3:0]  e_stat,
    input  logic [3:0]  e_icode,
    input  logic        e_cnd,
    input  logic [63:0] e_valE,
    input  logic [63:0] e_valA,
    input  logic [3:0]  e_dstE,
    input  logic [3:0]  e_dstM,
    // hazard control
    input  logic        M_stall,
    input  logic        M_bubble,
    // E/M register contents, used for forwarding
    output logic [3:0]  M_stat,
    output logic [3:0]  M_icode,
    output logic        M_cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    // memory stage results
    output logic [63:0] m_valM,
    output logic [3:0]  m_stat,
    output logic        m_busy,
    // data memory handshake
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    input  logic        dmem_err
);

    localparam logic [3:0] STAT_AOK = 4'b0001;
    localparam logic [3:0] STAT_ADR = 4'b0100;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] REG_NONE = 4'hF;

    // Highest byte address at which a full 8-byte access still fits.
    localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } em_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [63:0] addr;
    } acc_t;

    localparam em_t EM_BUBBLE = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        cnd:   1'b0,
        valE:  64'd0,
        valA:  64'd0,
        dstE:  REG_NONE,
        dstM:  REG_NONE
    };

    // Which memory access (if any) an instruction performs, and at what address.
    function automatic acc_t decode(em_t r);
        acc_t a;
        a.rd   = 1'b0;
        a.wr   = 1'b0;
        a.addr = r.valE;
        case (r.icode)
            I_RMMOVQ, I_CALL, I_PUSHQ: a.wr = 1'b1;
            I_MRMOVQ:                  a.rd = 1'b1;
            I_RET, I_POPQ: begin
                a.rd   = 1'b1;
                a.addr = r.valA;
            end
            default: ;
        endcase
        return a;
    endfunction

    state_e            state_q, state_d;
    em_t               em_q, em_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       valm_q, valm_d;
    logic              err_q, err_d;

    logic              in_req;
    logic              load;
    acc_t              acc_d, acc_q;
    logic              issue_d;
    logic              addr_bad_q;

    // The register only advances while no access is outstanding; stall wins over bubble.
    assign in_req = (state_q == S_REQ);
    assign load   = !M_stall && !in_req;

    assign acc_d   = decode(em_d);
    assign acc_q   = decode(em_q);
    assign issue_d = (acc_d.rd || acc_d.wr) && (em_d.stat == STAT_AOK) && (acc_d.addr <= ADDR_MAX);

    assign addr_bad_q = (acc_q.rd || acc_q.wr) && (em_q.stat == STAT_AOK) && (acc_q.addr > ADDR_MAX);

    // E/M register next value: hold, bubble, or take the execute outputs.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        em_d = em_q;
        if (load) begin
            if (M_bubble) begin
                em_d = EM_BUBBLE;
            end else begin
                em_d = '{stat: e_stat, icode: e_icode, cnd: e_cnd, valE: e_valE,
                         valA: e_valA, dstE: e_dstE, dstM: e_dstM};
            end
        end
    end

    // E/M pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_q <= EM_BUBBLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            em_q <= em_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, decided on the values being loaded into E/M.
    always_comb begin
        state_d = state_q;
        if (load) begin
            if (M_bubble)     state_d = S_IDLE;
            else if (issue_d) state_d = S_REQ;
            else              state_d = S_DONE;
        end else if (in_req && (dmem_ack || (cnt_q == CNT_LAST))) begin
            state_d = S_DONE;
        end
    end

    // Access datapath: cycle counter, captured read data and error flag.
    always_comb begin
        cnt_d  = cnt_q;
        valm_d = valm_q;
        err_d  = err_q;
        if (load) begin
            cnt_d  = '0;
            valm_d = 64'd0;
            err_d  = 1'b0;
        end else if (in_req) begin
            cnt_d = cnt_q + 1'b1;
            if (dmem_ack) begin
                err_d = dmem_err;
                if (acc_q.rd) valm_d = dmem_rdata;
            end else if (cnt_q == CNT_LAST) begin
                err_d = 1'b1;
            end
        end
    end

    // Access datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            valm_q <= 64'd0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            valm_q <= valm_d;
            err_q  <= err_d;
        end
    end

    // FSM outputs and memory-stage results, all from registered state.
    always_comb begin
        dmem_req   = in_req;
        m_busy     = in_req;
        dmem_we    = in_req && acc_q.wr;
        dmem_addr  = in_req ? acc_q.addr : 64'd0;
        dmem_wdata = in_req ? em_q.valA : 64'd0;

        if (state_q == S_IDLE)        m_stat = STAT_AOK;
        else if (err_q || addr_bad_q) m_stat = STAT_ADR;
        else                          m_stat = em_q.stat;

        m_valM = 64'd0;
        if ((state_q == S_DONE) && acc_q.rd && !err_q) m_valM = valm_q;
    end

    assign M_stat  = em_q.stat;
    assign M_icode = em_q.icode;
    assign M_cnd   = em_q.cnd;
    assign M_valE  = em_q.valE;
    assign M_valA  = em_q.valA;
    assign M_dstE  = em_q.dstE;
    assign M_dstM  = em_q.dstM;

endmodule
